// File: rtl/cbus_arbiter.sv
// N-channel cached-bus arbiter: merges upstream request ports onto one
// downstream cbus port with fixed-priority or round-robin selection and a
// grant held for the whole burst.
module cbus_arbiter #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned RR_EN  = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [N_CH-1:0]                              ireq_valid,
  input  logic [N_CH-1:0]                              ireq_is_write,
  input  logic [3*N_CH-1:0]                            ireq_size,
  input  logic [ADDR_W*N_CH-1:0]                       ireq_addr,
  input  logic [(DATA_W/8)*N_CH-1:0]                   ireq_strobe,
  input  logic [DATA_W*N_CH-1:0]                       ireq_data,
  input  logic [LEN_W*N_CH-1:0]                        ireq_len,
  output logic [N_CH-1:0]                              iresp_ready,
  output logic [N_CH-1:0]                              iresp_last,
  output logic [DATA_W*N_CH-1:0]                       iresp_data,
  output logic                                         oreq_valid,
  output logic                                         oreq_is_write,
  output logic [2:0]                                   oreq_size,
  output logic [ADDR_W-1:0]                            oreq_addr,
  output logic [DATA_W/8-1:0]                          oreq_strobe,
  output logic [DATA_W-1:0]                            oreq_data,
  output logic [LEN_W-1:0]                             oreq_len,
  input  logic                                         oresp_ready,
  input  logic                                         oresp_last,
  input  logic [DATA_W-1:0]                            oresp_data,
  output logic                                         busy,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   grant_idx,
  output logic                                         proto_err
);

  localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = LEN_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   grant_d;
  logic [IDX_W-1:0]   rr_ptr, rr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   beat_cnt, cnt_d;
  logic               err_d;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  int unsigned        cand;
  logic               busy_st;

  // Per-channel views of the flattened request buses
  logic [2:0]         size_a [N_CH];
  logic [ADDR_W-1:0]  addr_a [N_CH];
  logic [STRB_W-1:0]  strb_a [N_CH];
  logic [DATA_W-1:0]  data_a [N_CH];
  logic [LEN_W-1:0]   len_a  [N_CH];

  assign busy_st = (state == BUSY);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic sel;
    assign size_a[g] = ireq_size[g*3 +: 3];
    assign addr_a[g] = ireq_addr[g*ADDR_W +: ADDR_W];
    assign strb_a[g] = ireq_strobe[g*STRB_W +: STRB_W];
    assign data_a[g] = ireq_data[g*DATA_W +: DATA_W];
    assign len_a[g]  = ireq_len[g*LEN_W +: LEN_W];
    // Downstream response reaches only the granted channel while busy
    assign sel                          = busy_st && (grant_idx == IDX_W'(g));
    assign iresp_ready[g]               = sel & oresp_ready;
    assign iresp_last[g]                = sel & oresp_last;
    assign iresp_data[g*DATA_W +: DATA_W] = sel ? oresp_data : '0;
  end

  // Downstream request mirrors the granted channel in BUSY, idles at zero
  assign oreq_valid    = busy_st & ireq_valid[grant_idx];
  assign oreq_is_write = busy_st & ireq_is_write[grant_idx];
  assign oreq_size     = busy_st ? size_a[grant_idx] : '0;
  assign oreq_addr     = busy_st ? addr_a[grant_idx] : '0;
  assign oreq_strobe   = busy_st ? strb_a[grant_idx] : '0;
  assign oreq_data     = busy_st ? data_a[grant_idx] : '0;
  assign oreq_len      = busy_st ? len_a[grant_idx]  : '0;
  assign busy          = busy_st;

  // Winner search: start at rr_ptr (round-robin) or at 0 (fixed priority)
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = (RR_EN != 0) ? (32'(rr_ptr) + i) : i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!win_found && ireq_valid[IDX_W'(cand)]) begin
        win_idx   = IDX_W'(cand);
        win_found = 1'b1;
      end
    end
  end

  // Next-state: grant in IDLE, count beats and release on last beat in BUSY
  always_comb begin
    state_d = state;
    grant_d = grant_idx;
    rr_d    = rr_ptr;
    len_d   = len_q;
    cnt_d   = beat_cnt;
    err_d   = proto_err;
    case (state)
      IDLE: begin
        if (|ireq_valid) begin
          grant_d = win_idx;
          len_d   = len_a[win_idx];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (oresp_ready) begin
          if (beat_cnt == ({1'b0, len_q} + CNT_W'(1))) err_d = 1'b1;
          if (beat_cnt != {CNT_W{1'b1}}) cnt_d = beat_cnt + CNT_W'(1);
          if (oresp_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            rr_d    = (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_d;
      grant_idx <= grant_d;
      rr_ptr    <= rr_d;
      len_q     <= len_d;
      beat_cnt  <= cnt_d;
      proto_err <= err_d;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: 3-channel round-robin instance plus a
// fixed-priority instance sharing the same stimulus.
module tb_cbus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    ireq_valid, ireq_is_write;
  logic [3*N-1:0]  ireq_size;
  logic [AW*N-1:0] ireq_addr;
  logic [SW*N-1:0] ireq_strobe;
  logic [DW*N-1:0] ireq_data;
  logic [LW*N-1:0] ireq_len;
  logic            oresp_ready, oresp_last;
  logic [DW-1:0]   oresp_data;

  logic [N-1:0]    iresp_ready, iresp_last;
  logic [DW*N-1:0] iresp_data;
  logic            oreq_valid, oreq_is_write;
  logic [2:0]      oreq_size;
  logic [AW-1:0]   oreq_addr;
  logic [SW-1:0]   oreq_strobe;
  logic [DW-1:0]   oreq_data;
  logic [LW-1:0]   oreq_len;
  logic            busy, proto_err;
  logic [1:0]      grant_idx;

  logic [N-1:0]    b_iresp_ready, b_iresp_last;
  logic [DW*N-1:0] b_iresp_data;
  logic            b_oreq_valid, b_oreq_is_write;
  logic [2:0]      b_oreq_size;
  logic [AW-1:0]   b_oreq_addr;
  logic [SW-1:0]   b_oreq_strobe;
  logic [DW-1:0]   b_oreq_data;
  logic [LW-1:0]   b_oreq_len;
  logic            b_busy, b_proto_err;
  logic [1:0]      b_grant_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RR_EN(1)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_size(ireq_size),
    .ireq_addr(ireq_addr), .ireq_strobe(ireq_strobe), .ireq_data(ireq_data), .ireq_len(ireq_len),
    .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
    .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_size(oreq_size),
    .oreq_addr(oreq_addr), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data), .oreq_len(oreq_len),
    .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
    .busy(busy), .grant_idx(grant_idx), .proto_err(proto_err)
  );

  cbus_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_size(ireq_size),
    .ireq_addr(ireq_addr), .ireq_strobe(ireq_strobe), .ireq_data(ireq_data), .ireq_len(ireq_len),
    .iresp_ready(b_iresp_ready), .iresp_last(b_iresp_last), .iresp_data(b_iresp_data),
    .oreq_valid(b_oreq_valid), .oreq_is_write(b_oreq_is_write), .oreq_size(b_oreq_size),
    .oreq_addr(b_oreq_addr), .oreq_strobe(b_oreq_strobe), .oreq_data(b_oreq_data), .oreq_len(b_oreq_len),
    .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
    .busy(b_busy), .grant_idx(b_grant_idx), .proto_err(b_proto_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] len);
    ireq_valid[ch]          = v;
    ireq_is_write[ch]       = wr;
    ireq_size[ch*3 +: 3]    = 3'd2;
    ireq_addr[ch*AW +: AW]  = addr;
    ireq_strobe[ch*SW +: SW] = wr ? 4'hF : 4'h0;
    ireq_data[ch*DW +: DW]  = data;
    ireq_len[ch*LW +: LW]   = len;
  endtask

  task automatic resp(input logic r, input logic l, input logic [31:0] d);
    oresp_ready = r;
    oresp_last  = l;
    oresp_data  = d;
  endtask

  // Bound the run in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ireq_valid = '0; ireq_is_write = '0; ireq_size = '0; ireq_addr = '0;
    ireq_strobe = '0; ireq_data = '0; ireq_len = '0;
    resp(1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Reset state
    check("rst_busy",        64'(busy), 64'd0);
    check("rst_grant",       64'(grant_idx), 64'd0);
    check("rst_proto_err",   64'(proto_err), 64'd0);
    check("rst_oreq_valid",  64'(oreq_valid), 64'd0);
    check("rst_oreq_addr",   64'(oreq_addr), 64'd0);
    check("rst_iresp_ready", 64'(iresp_ready), 64'd0);
    reset = 1'b0;

    // Single read on ch0 with one bubble cycle before downstream valid
    set_ch(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'd0);
    #1;
    check("t1_bubble_valid", 64'(oreq_valid), 64'd0);
    tick();
    check("t1_busy",       64'(busy), 64'd1);
    check("t1_grant",      64'(grant_idx), 64'd0);
    check("t1_oreq_valid", 64'(oreq_valid), 64'd1);
    check("t1_oreq_addr",  64'(oreq_addr), 64'h1000);
    check("t1_oreq_wr",    64'(oreq_is_write), 64'd0);
    resp(1'b1, 1'b1, 32'hDEADBEEF);
    #1;
    check("t1_iresp_ready", 64'(iresp_ready), 64'b001);
    check("t1_iresp_last",  64'(iresp_last), 64'b001);
    check("t1_iresp_data0", 64'(iresp_data[31:0]), 64'hDEADBEEF);
    check("t1_iresp_upper", 64'(iresp_data[95:32]), 64'h0);
    tick();
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    resp(1'b0, 1'b0, 32'h0);
    #1;
    check("t1_idle_busy", 64'(busy), 64'd0);

    // Burst lock: ch1 4-beat write, ch0 arrives during beat 2
    set_ch(1, 1'b1, 1'b1, 32'h2000, 32'h11111111, 4'd3);
    tick();
    check("t2_grant",    64'(grant_idx), 64'd1);
    check("t2_oreq_wr",  64'(oreq_is_write), 64'd1);
    check("t2_oreq_len", 64'(oreq_len), 64'd3);
    check("t2_oreq_data", 64'(oreq_data), 64'h11111111);
    check("t2_oreq_strb", 64'(oreq_strobe), 64'hF);
    resp(1'b1, 1'b0, 32'hA0);
    #1;
    check("t2_beat1_ready", 64'(iresp_ready), 64'b010);
    tick();
    set_ch(0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'd0);
    resp(1'b1, 1'b0, 32'hA1);
    #1;
    check("t2_beat2_grant", 64'(grant_idx), 64'd1);
    check("t2_beat2_ready", 64'(iresp_ready), 64'b010);
    check("t2_beat2_addr",  64'(oreq_addr), 64'h2000);
    tick();
    resp(1'b1, 1'b0, 32'hA2);
    #1;
    check("t2_beat3_ready", 64'(iresp_ready), 64'b010);
    tick();
    resp(1'b1, 1'b1, 32'hA3);
    #1;
    check("t2_beat4_ready", 64'(iresp_ready), 64'b010);
    check("t2_beat4_last",  64'(iresp_last), 64'b010);
    check("t2_beat4_data",  64'(iresp_data[63:32]), 64'hA3);
    check("t2_beat4_ch0",   64'(iresp_data[31:0]), 64'h0);
    tick();
    resp(1'b0, 1'b0, 32'h0);
    #1;
    check("t2_release_busy", 64'(busy), 64'd0);
    check("t2_release_err",  64'(proto_err), 64'd0);

    // Wrap-around: rr_ptr is now 2, ch0 and ch1 both valid -> ch0
    tick();
    check("t3_wrap_grant", 64'(grant_idx), 64'd0);
    check("t3_wrap_addr",  64'(oreq_addr), 64'h3000);
    resp(1'b1, 1'b1, 32'hB0);
    #1;
    check("t3_ready", 64'(iresp_ready), 64'b001);
    tick();
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    resp(1'b0, 1'b0, 32'h0);

    // Protocol error: len=1 but three beats returned, last on the third
    set_ch(1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'd1);
    tick();
    check("t4_grant", 64'(grant_idx), 64'd1);
    resp(1'b1, 1'b0, 32'hC0);
    tick();
    resp(1'b1, 1'b0, 32'hC1);
    tick();
    check("t4_err_before", 64'(proto_err), 64'd0);
    check("t4_busy_extra", 64'(busy), 64'd1);
    resp(1'b1, 1'b1, 32'hC2);
    tick();
    check("t4_err_set",  64'(proto_err), 64'd1);
    check("t4_err_idle", 64'(busy), 64'd0);
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    resp(1'b0, 1'b0, 32'h0);

    // Reset during beat 2 of a 4-beat burst on ch2 (rr_ptr is 2 here)
    set_ch(2, 1'b1, 1'b0, 32'h5000, 32'h0, 4'd3);
    tick();
    check("t5_grant", 64'(grant_idx), 64'd2);
    resp(1'b1, 1'b0, 32'hD0);
    tick();
    resp(1'b1, 1'b0, 32'hD1);
    reset = 1'b1;
    tick();
    check("t5_busy",        64'(busy), 64'd0);
    check("t5_proto_err",   64'(proto_err), 64'd0);
    check("t5_grant_rst",   64'(grant_idx), 64'd0);
    check("t5_oreq_valid",  64'(oreq_valid), 64'd0);
    check("t5_oreq_addr",   64'(oreq_addr), 64'd0);
    check("t5_iresp_ready", 64'(iresp_ready), 64'd0);
    check("t5_iresp_data",  64'(iresp_data[95:64]), 64'd0);
    reset = 1'b0;
    resp(1'b0, 1'b0, 32'h0);
    set_ch(1, 1'b1, 1'b0, 32'h6000, 32'h0, 4'd0);
    tick();
    // rr_ptr back at 0: ch1 beats ch2
    check("t5_rr_cleared", 64'(grant_idx), 64'd1);
    resp(1'b1, 1'b1, 32'hE0);
    tick();
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    set_ch(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    resp(1'b0, 1'b0, 32'h0);

    // Fairness: all three hold valid with single-beat requests
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b0, 32'h100 * (c + 1), 32'h0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t6_rr_grant%0d", k), 64'(grant_idx), 64'(k % 3));
      check($sformatf("t6_fp_grant%0d", k), 64'(b_grant_idx), 64'd0);
      resp(1'b1, 1'b1, 32'(k));
      tick();
      resp(1'b0, 1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
